// File: rtl/seg_scan_decoder_if.sv
// Multiplexed 7-segment bus as seen by the scan decoder, plus its recovered-frame outputs.
// master drives the segment bus; slave is the decoder.
interface seg_scan_decoder_if #(
  parameter int unsigned DIGITS = 4
);
  logic [7:0]          seg;
  logic [DIGITS-1:0]   dig_sel;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   digit_err;
  logic                frame_valid;
  logic [7:0]          frame_cnt;

  modport master (
    output seg, dig_sel,
    input  bcd, digit_err, frame_valid, frame_cnt
  );

  modport slave (
    input  seg, dig_sel,
    output bcd, digit_err, frame_valid, frame_cnt
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers BCD digits from a multiplexed 7-segment bus: debounces each digit dwell,
// decodes the pattern and publishes a frame once every position has been captured.
module seg_scan_decoder #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned STABLE = 3
) (
  input logic               clk,
  input logic               rst_n,
  seg_scan_decoder_if.slave bus
);
  localparam int unsigned RunW = $clog2(STABLE + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(STABLE);
  localparam logic [RunW-1:0] RunCap = RunW'(STABLE - 1);

  typedef enum logic [0:0] {StCollect, StPublish} state_e;

  state_e              state_q, state_d;
  logic [7:0]          s_seg_q;
  logic [DIGITS-1:0]   s_sel_q;
  logic [RunW-1:0]     run_q, run_d;
  logic [4*DIGITS-1:0] wbcd_q, wbcd_d, bcd_q, bcd_d;
  logic [DIGITS-1:0]   werr_q, werr_d, err_q, err_d, mask_q, mask_d, mask_new;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic                onehot, same, capture, complete, publish;
  logic [3:0]          dec_val;
  logic                dec_err;

  assign onehot = (bus.dig_sel != '0) && ((bus.dig_sel & (bus.dig_sel - DIGITS'(1))) == '0);
  assign same   = ({bus.seg, bus.dig_sel} == {s_seg_q, s_sel_q});

  always_comb begin
    run_d = '0;
    if (onehot) begin
      if (!same)                run_d = RunW'(1);
      else if (run_q == RunMax) run_d = RunMax;
      else                      run_d = run_q + RunW'(1);
    end
  end

  // Saturation at RunMax means a long dwell never re-enters the capture condition.
  assign capture = onehot && same && (run_q == RunCap);

  always_comb begin
    dec_err = 1'b0;
    unique case (bus.seg)
      8'hBF:   dec_val = 4'd0;
      8'h86:   dec_val = 4'd1;
      8'hDB:   dec_val = 4'd2;
      8'hCF:   dec_val = 4'd3;
      8'hE6:   dec_val = 4'd4;
      8'hED:   dec_val = 4'd5;
      8'hFD:   dec_val = 4'd6;
      8'h87:   dec_val = 4'd7;
      8'hFF:   dec_val = 4'd8;
      8'hEF:   dec_val = 4'd9;
      default: begin
        dec_val = 4'hF;
        dec_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    wbcd_d   = wbcd_q;
    werr_d   = werr_q;
    mask_new = mask_q;
    if (capture) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (bus.dig_sel[i]) begin
          wbcd_d[4*i +: 4] = dec_val;
          werr_d[i]        = dec_err;
          mask_new[i]      = 1'b1;
        end
      end
    end
  end

  assign complete    = capture && (&mask_new);
  assign publish     = complete && (state_q == StCollect);
  assign mask_d      = publish ? '0 : mask_new;
  assign bcd_d       = publish ? wbcd_d : bcd_q;
  assign err_d       = publish ? werr_d : err_q;
  assign frame_cnt_d = publish ? frame_cnt_q + 8'd1 : frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg_q     <= '0;
      s_sel_q     <= '0;
      run_q       <= '0;
      wbcd_q      <= '0;
      werr_q      <= '0;
      mask_q      <= '0;
      bcd_q       <= '0;
      err_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      s_seg_q     <= bus.seg;
      s_sel_q     <= bus.dig_sel;
      run_q       <= run_d;
      wbcd_q      <= wbcd_d;
      werr_q      <= werr_d;
      mask_q      <= mask_d;
      bcd_q       <= bcd_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StCollect;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCollect: if (complete) state_d = StPublish;
      StPublish: state_d = StCollect;
      default:   state_d = StCollect;
    endcase
  end

  always_comb begin
    bus.frame_valid = (state_q == StPublish);
  end

  assign bus.bcd       = bcd_q;
  assign bus.digit_err = err_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with DIGITS=4, STABLE=3.
module tb_seg_scan_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails = 0;
  int   pulses = 0;

  always #5 clk = ~clk;

  seg_scan_decoder_if #(.DIGITS(4)) bus ();

  seg_scan_decoder #(.DIGITS(4), .STABLE(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a code on a select for n rising edges, counting frame_valid pulses seen after each.
  task automatic drive(input logic [7:0] s, input logic [3:0] sel, input int n);
    bus.seg     = s;
    bus.dig_sel = sel;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.frame_valid) pulses++;
    end
  endtask

  function automatic logic [7:0] code_of(input int d);
    case (d)
      0: return 8'hBF; 1: return 8'h86; 2: return 8'hDB; 3: return 8'hCF; 4: return 8'hE6;
      5: return 8'hED; 6: return 8'hFD; 7: return 8'h87; 8: return 8'hFF; default: return 8'hEF;
    endcase
  endfunction

  initial begin
    bus.seg     = 8'h00;
    bus.dig_sel = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_bcd", 32'(bus.bcd), 32'h0);
    check("reset_err", 32'(bus.digit_err), 32'h0);
    check("reset_cnt", 32'(bus.frame_cnt), 32'h0);
    check("reset_fv", 32'(bus.frame_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean frame "1 2 3 4"
    pulses = 0;
    drive(8'h86, 4'b0001, 3);
    drive(8'hDB, 4'b0010, 3);
    drive(8'hCF, 4'b0100, 3);
    drive(8'hE6, 4'b1000, 3);
    check("clean_pulses", 32'(pulses), 32'd1);
    check("clean_bcd", 32'(bus.bcd), 32'h4321);
    check("clean_err", 32'(bus.digit_err), 32'h0);
    check("clean_cnt", 32'(bus.frame_cnt), 32'd1);
    drive(8'h00, 4'b0000, 1);
    check("fv_one_cycle", 32'(bus.frame_valid), 32'h0);
    check("bcd_hold", 32'(bus.bcd), 32'h4321);

    // Glitch rejection: 2-cycle dwell ignored, 3-cycle dwell captured
    pulses = 0;
    drive(8'h86, 4'b0001, 2);
    check("glitch_mask", 32'(dut.mask_q), 32'h0);
    drive(8'h86, 4'b0010, 3);
    check("dwell3_mask", 32'(dut.mask_q), 32'h2);
    drive(8'hBF, 4'b0001, 3);
    drive(8'hFD, 4'b0100, 3);
    drive(8'hEF, 4'b1000, 3);
    check("glitch_pulses", 32'(pulses), 32'd1);
    check("glitch_bcd", 32'(bus.bcd), 32'h9610);
    check("glitch_cnt", 32'(bus.frame_cnt), 32'd2);

    // Illegal pattern on digit 2
    pulses = 0;
    drive(8'hBF, 4'b0001, 3);
    drive(8'h87, 4'b0010, 3);
    drive(8'h7F, 4'b0100, 3);
    drive(8'hFF, 4'b1000, 3);
    check("illegal_bcd", 32'(bus.bcd), 32'h8F70);
    check("illegal_err", 32'(bus.digit_err), 32'h4);
    check("illegal_cnt", 32'(bus.frame_cnt), 32'd3);

    // Bad select: multi-hot then none
    pulses = 0;
    drive(8'h86, 4'b0011, 10);
    check("multihot_run", 32'(dut.run_q), 32'h0);
    drive(8'h86, 4'b0000, 10);
    check("nosel_run", 32'(dut.run_q), 32'h0);
    check("badsel_mask", 32'(dut.mask_q), 32'h0);
    check("badsel_pulses", 32'(pulses), 32'd0);
    check("badsel_bcd", 32'(bus.bcd), 32'h8F70);

    // Long dwell captures once and saturates
    drive(8'hBF, 4'b0001, 20);
    check("dwell_run_sat", 32'(dut.run_q), 32'd3);
    check("dwell_mask", 32'(dut.mask_q), 32'h1);
    drive(8'hED, 4'b0010, 3);
    drive(8'hED, 4'b0100, 3);
    drive(8'h86, 4'b1000, 3);
    check("dwell_bcd", 32'(bus.bcd), 32'h1550);
    check("dwell_cnt", 32'(bus.frame_cnt), 32'd4);

    // Counter wrap: 251 more frames to reach 255, then one to wrap
    pulses = 0;
    for (int k = 0; k < 251; k++) begin
      for (int p = 0; p < 4; p++) drive(code_of((k % 9) + 1), 4'(1 << p), 3);
    end
    check("wrap_pulses", 32'(pulses), 32'd251);
    check("cnt_255", 32'(bus.frame_cnt), 32'd255);
    check("bcd_8888", 32'(bus.bcd), 32'h8888);
    drive(8'h86, 4'b0001, 3);
    drive(8'hDB, 4'b0010, 3);
    drive(8'hCF, 4'b0100, 3);
    drive(8'hE6, 4'b1000, 3);
    check("cnt_wrap0", 32'(bus.frame_cnt), 32'd0);
    check("wrap_fv", 32'(bus.frame_valid), 32'd1);

    // Frame with an illegal digit, then a mid-frame reset
    drive(8'hEF, 4'b0001, 3);
    drive(8'h00, 4'b0010, 3);
    drive(8'h87, 4'b0100, 3);
    drive(8'hFD, 4'b1000, 3);
    check("pre_rst_bcd", 32'(bus.bcd), 32'h67F9);
    check("pre_rst_err", 32'(bus.digit_err), 32'h2);
    check("pre_rst_cnt", 32'(bus.frame_cnt), 32'd1);
    drive(8'hBF, 4'b0001, 3);
    drive(8'h86, 4'b0010, 3);
    check("mid_mask", 32'(dut.mask_q), 32'h3);
    rst_n = 1'b0;
    #1;
    check("rst_bcd", 32'(bus.bcd), 32'h0);
    check("rst_err", 32'(bus.digit_err), 32'h0);
    check("rst_cnt", 32'(bus.frame_cnt), 32'h0);
    check("rst_fv", 32'(bus.frame_valid), 32'h0);
    check("rst_mask", 32'(dut.mask_q), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    drive(8'hED, 4'b0001, 3);
    drive(8'hFD, 4'b0010, 3);
    drive(8'h87, 4'b0100, 3);
    drive(8'hFF, 4'b1000, 3);
    check("post_rst_pulses", 32'(pulses), 32'd1);
    check("post_rst_bcd", 32'(bus.bcd), 32'h8765);
    check("post_rst_err", 32'(bus.digit_err), 32'h0);
    check("post_rst_cnt", 32'(bus.frame_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end
endmodule
